// File: rtl/instr_register_pipe.sv
// instr_register_pipe
//   Instruction register file with a two-stage read/execute pipeline.
//   Entries hold {opcode, operand_a, operand_b} plus a valid bit. A read
//   captures the addressed entry in stage 1, and stage 2 evaluates the
//   signed ALU operation and registers every rd_* output.
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   load_en        write strobe; stores the entry at write_pointer
//   write_pointer  write address (AW bits)
//   opcode         ZERO/PASSA/PASSB/ADD/SUB/MULT/DIV/MOD (0..7)
//   operand_a/b    signed operands (OP_W bits)
//   clear_all      synchronous invalidate of all entries
//   read_en        read request
//   read_pointer   read address (AW bits)
//   rd_valid       result strobe, two edges after read_en is sampled
//   rd_hit         addressed entry was valid
//   rd_opc/op_a/op_b  stored fields (zero on a miss)
//   rd_result      signed ALU result (RES_W bits)
//   rd_err         DIV/MOD by zero
//   valid_count    number of valid entries, one cycle behind the valid bits
module instr_register_pipe #(
  parameter int DEPTH = 32,
  parameter int OP_W  = 32,
  parameter int RES_W = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_en,
  input  logic [AW-1:0]     write_pointer,
  input  logic [2:0]        opcode,
  input  logic [OP_W-1:0]   operand_a,
  input  logic [OP_W-1:0]   operand_b,
  input  logic              clear_all,
  input  logic              read_en,
  input  logic [AW-1:0]     read_pointer,
  output logic              rd_valid,
  output logic              rd_hit,
  output logic [2:0]        rd_opc,
  output logic [OP_W-1:0]   rd_op_a,
  output logic [OP_W-1:0]   rd_op_b,
  output logic [RES_W-1:0]  rd_result,
  output logic              rd_err,
  output logic [AW:0]       valid_count
);

  localparam logic [2:0] OPC_ZERO  = 3'd0;
  localparam logic [2:0] OPC_PASSA = 3'd1;
  localparam logic [2:0] OPC_PASSB = 3'd2;
  localparam logic [2:0] OPC_ADD   = 3'd3;
  localparam logic [2:0] OPC_SUB   = 3'd4;
  localparam logic [2:0] OPC_MULT  = 3'd5;
  localparam logic [2:0] OPC_DIV   = 3'd6;
  localparam logic [2:0] OPC_MOD   = 3'd7;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  function automatic logic [AW:0] count_ones(input logic [DEPTH-1:0] v);
    logic [AW:0] c;
    c = {(AW+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Storage (no reset needed) and valid bits
  logic [2:0]       r_mem_opc [DEPTH];
  logic [OP_W-1:0]  r_mem_a   [DEPTH];
  logic [OP_W-1:0]  r_mem_b   [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] w_valid_nxt;
  logic [AW:0]      r_valid_count;

  // Stage 1 registers
  logic             r_s1_valid;
  logic             r_s1_hit;
  logic [2:0]       r_s1_opc;
  logic [OP_W-1:0]  r_s1_a;
  logic [OP_W-1:0]  r_s1_b;

  // Stage 2 (output) registers
  logic             r_rd_valid;
  logic             r_rd_hit;
  logic [2:0]       r_rd_opc;
  logic [OP_W-1:0]  r_rd_op_a;
  logic [OP_W-1:0]  r_rd_op_b;
  logic [RES_W-1:0] r_rd_result;
  logic             r_rd_err;

  logic             w_wr_ok;
  logic             w_hit;
  logic [2:0]       w_opc;
  logic [OP_W-1:0]  w_a;
  logic [OP_W-1:0]  w_b;

  assign w_wr_ok = load_en && ({1'b0, write_pointer} < DEPTH_L);

  // Storage write; out-of-range pointers leave the array untouched
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem_opc[write_pointer] <= opcode;
      r_mem_a[write_pointer]   <= operand_a;
      r_mem_b[write_pointer]   <= operand_b;
    end
  end

  // Next valid vector: clear first so a same-cycle write survives the clear
  always_comb begin
    w_valid_nxt = r_valid;
    if (clear_all) begin
      w_valid_nxt = {DEPTH{1'b0}};
    end else begin
      w_valid_nxt = r_valid;
    end
    if (w_wr_ok) begin
      w_valid_nxt[write_pointer] = 1'b1;
    end else begin
      w_valid_nxt[write_pointer] = w_valid_nxt[write_pointer];
    end
  end

  // Valid bits and population count (count trails the bits by one cycle)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid       <= {DEPTH{1'b0}};
      r_valid_count <= {(AW+1){1'b0}};
    end else begin
      r_valid       <= w_valid_nxt;
      r_valid_count <= count_ones(r_valid);
    end
  end

  // Stage 1 lookup: same-address write bypasses the array; the pre-edge
  // valid bits are used, so a read alongside clear_all sees pre-clear state
  always_comb begin
    w_hit = 1'b0;
    w_opc = 3'd0;
    w_a   = {OP_W{1'b0}};
    w_b   = {OP_W{1'b0}};
    if (w_wr_ok && (write_pointer == read_pointer)) begin
      w_hit = 1'b1;
      w_opc = opcode;
      w_a   = operand_a;
      w_b   = operand_b;
    end else if (({1'b0, read_pointer} < DEPTH_L) && r_valid[read_pointer]) begin
      w_hit = 1'b1;
      w_opc = r_mem_opc[read_pointer];
      w_a   = r_mem_a[read_pointer];
      w_b   = r_mem_b[read_pointer];
    end else begin
      w_hit = 1'b0;
    end
  end

  // Stage 1 register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_hit   <= 1'b0;
      r_s1_opc   <= 3'd0;
      r_s1_a     <= {OP_W{1'b0}};
      r_s1_b     <= {OP_W{1'b0}};
    end else begin
      r_s1_valid <= read_en;
      if (read_en) begin
        r_s1_hit <= w_hit;
        r_s1_opc <= w_opc;
        r_s1_a   <= w_a;
        r_s1_b   <= w_b;
      end else begin
        r_s1_hit <= 1'b0;
        r_s1_opc <= 3'd0;
        r_s1_a   <= {OP_W{1'b0}};
        r_s1_b   <= {OP_W{1'b0}};
      end
    end
  end

  // Signed ALU. Division runs one bit wider so MIN / -1 yields +2^(OP_W-1).
  logic signed [OP_W-1:0]   w_a_s;
  logic signed [OP_W-1:0]   w_b_s;
  logic signed [OP_W:0]     w_a_x;
  logic signed [OP_W:0]     w_div_b;
  logic signed [OP_W:0]     w_quot;
  logic signed [OP_W:0]     w_rem;
  logic signed [2*OP_W-1:0] w_prod;
  logic                     w_b_zero;
  logic [RES_W-1:0]         w_result;
  logic                     w_err;

  // ALU evaluation on the stage 1 entry
  always_comb begin
    w_a_s    = r_s1_a;
    w_b_s    = r_s1_b;
    w_a_x    = {r_s1_a[OP_W-1], r_s1_a};
    w_b_zero = (r_s1_b == {OP_W{1'b0}});
    if (w_b_zero) begin
      w_div_b = {{OP_W{1'b0}}, 1'b1};
    end else begin
      w_div_b = {r_s1_b[OP_W-1], r_s1_b};
    end
    w_quot   = w_a_x / w_div_b;
    w_rem    = w_a_x % w_div_b;
    w_prod   = (2*OP_W)'(w_a_s) * (2*OP_W)'(w_b_s);
    w_result = {RES_W{1'b0}};
    w_err    = 1'b0;
    case (r_s1_opc)
      OPC_ZERO:  w_result = {RES_W{1'b0}};
      OPC_PASSA: w_result = RES_W'(w_a_s);
      OPC_PASSB: w_result = RES_W'(w_b_s);
      OPC_ADD:   w_result = RES_W'(w_a_s) + RES_W'(w_b_s);
      OPC_SUB:   w_result = RES_W'(w_a_s) - RES_W'(w_b_s);
      OPC_MULT:  w_result = RES_W'(w_prod);
      OPC_DIV: begin
        if (w_b_zero) begin
          w_result = {RES_W{1'b0}};
          w_err    = 1'b1;
        end else begin
          w_result = RES_W'(w_quot);
        end
      end
      OPC_MOD: begin
        if (w_b_zero) begin
          w_result = {RES_W{1'b0}};
          w_err    = 1'b1;
        end else begin
          w_result = RES_W'(w_rem);
        end
      end
      default:   w_result = {RES_W{1'b0}};
    endcase
  end

  // Stage 2 register: outputs are zero whenever no result is presented
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid  <= 1'b0;
      r_rd_hit    <= 1'b0;
      r_rd_opc    <= 3'd0;
      r_rd_op_a   <= {OP_W{1'b0}};
      r_rd_op_b   <= {OP_W{1'b0}};
      r_rd_result <= {RES_W{1'b0}};
      r_rd_err    <= 1'b0;
    end else begin
      r_rd_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rd_hit    <= r_s1_hit;
        r_rd_opc    <= r_s1_opc;
        r_rd_op_a   <= r_s1_a;
        r_rd_op_b   <= r_s1_b;
        r_rd_result <= w_result;
        r_rd_err    <= w_err;
      end else begin
        r_rd_hit    <= 1'b0;
        r_rd_opc    <= 3'd0;
        r_rd_op_a   <= {OP_W{1'b0}};
        r_rd_op_b   <= {OP_W{1'b0}};
        r_rd_result <= {RES_W{1'b0}};
        r_rd_err    <= 1'b0;
      end
    end
  end

  assign rd_valid    = r_rd_valid;
  assign rd_hit      = r_rd_hit;
  assign rd_opc      = r_rd_opc;
  assign rd_op_a     = r_rd_op_a;
  assign rd_op_b     = r_rd_op_b;
  assign rd_result   = r_rd_result;
  assign rd_err      = r_rd_err;
  assign valid_count = r_valid_count;

endmodule

// File: tb/tb_instr_register_pipe.sv
// Directed testbench for instr_register_pipe (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_instr_register_pipe;

  localparam logic [2:0] ZERO  = 3'd0;
  localparam logic [2:0] PASSA = 3'd1;
  localparam logic [2:0] PASSB = 3'd2;
  localparam logic [2:0] ADD   = 3'd3;
  localparam logic [2:0] SUB   = 3'd4;
  localparam logic [2:0] MULT  = 3'd5;
  localparam logic [2:0] DIV   = 3'd6;
  localparam logic [2:0] MOD   = 3'd7;

  logic        clk;
  logic        reset_n;
  logic        load_en;
  logic [4:0]  write_pointer;
  logic [2:0]  opcode;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        clear_all;
  logic        read_en;
  logic [4:0]  read_pointer;
  logic        rd_valid;
  logic        rd_hit;
  logic [2:0]  rd_opc;
  logic [31:0] rd_op_a;
  logic [31:0] rd_op_b;
  logic [63:0] rd_result;
  logic        rd_err;
  logic [5:0]  valid_count;

  int checks;
  int failures;

  instr_register_pipe dut (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .write_pointer(write_pointer),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .clear_all(clear_all), .read_en(read_en), .read_pointer(read_pointer),
    .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_opc(rd_opc), .rd_op_a(rd_op_a),
    .rd_op_b(rd_op_b), .rd_result(rd_result), .rd_err(rd_err),
    .valid_count(valid_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [2:0] opc,
                          input logic [31:0] a, input logic [31:0] b);
    load_en = 1'b1; write_pointer = addr; opcode = opc; operand_a = a; operand_b = b;
    cyc();
    load_en = 1'b0;
  endtask

  // Issue one read and wait until its result is on the outputs.
  task automatic do_read(input logic [4:0] addr);
    read_en = 1'b1; read_pointer = addr;
    cyc();
    read_en = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load_en = 1'b0; clear_all = 1'b0; read_en = 1'b0;
    write_pointer = 5'd0; read_pointer = 5'd0; opcode = 3'd0;
    operand_a = 32'd0; operand_b = 32'd0;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_hit !== 1'b0) begin failures++; $display("FAIL reset_rd_hit got=%b exp=0", rd_hit); end
    checks++; if (rd_result !== 64'd0) begin failures++; $display("FAIL reset_rd_result got=%h exp=0", rd_result); end
    checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL reset_rd_err got=%b exp=0", rd_err); end
    checks++; if (valid_count !== 6'd0) begin failures++; $display("FAIL reset_valid_count got=%0d exp=0", valid_count); end
  endtask

  task automatic test_add();
    do_write(5'd5, ADD, 32'hFFFF_FFF1, 32'd7);
    do_read(5'd5);
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL add_rd_valid got=%b exp=1", rd_valid); end
    checks++; if (rd_hit !== 1'b1) begin failures++; $display("FAIL add_rd_hit got=%b exp=1", rd_hit); end
    checks++; if (rd_result !== 64'hFFFF_FFFF_FFFF_FFF8) begin failures++; $display("FAIL add_result got=%h exp=fffffffffffffff8", rd_result); end
    checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL add_err got=%b exp=0", rd_err); end
    checks++; if (rd_opc !== ADD) begin failures++; $display("FAIL add_opc got=%0d exp=3", rd_opc); end
    checks++; if (rd_op_a !== 32'hFFFF_FFF1) begin failures++; $display("FAIL add_op_a got=%h exp=fffffff1", rd_op_a); end
    checks++; if (rd_op_b !== 32'd7) begin failures++; $display("FAIL add_op_b got=%h exp=7", rd_op_b); end
    checks++; if (valid_count !== 6'd1) begin failures++; $display("FAIL add_valid_count got=%0d exp=1", valid_count); end
    cyc();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL add_single_pulse got=%b exp=0", rd_valid); end
  endtask

  task automatic test_alu_ops();
    logic [4:0]  t_addr [12];
    logic [2:0]  t_opc  [12];
    logic [31:0] t_a    [12];
    logic [31:0] t_b    [12];
    logic [63:0] t_res  [12];
    logic        t_err  [12];
    t_addr[0]  = 5'd31; t_opc[0]  = DIV;   t_a[0]  = 32'd9;          t_b[0]  = 32'd0;          t_res[0]  = 64'd0;                  t_err[0]  = 1'b1;
    t_addr[1]  = 5'd30; t_opc[1]  = MOD;   t_a[1]  = 32'hFFFF_FFF9;  t_b[1]  = 32'd3;          t_res[1]  = 64'hFFFF_FFFF_FFFF_FFFF; t_err[1]  = 1'b0;
    t_addr[2]  = 5'd29; t_opc[2]  = DIV;   t_a[2]  = 32'hFFFF_FFF9;  t_b[2]  = 32'd2;          t_res[2]  = 64'hFFFF_FFFF_FFFF_FFFD; t_err[2]  = 1'b0;
    t_addr[3]  = 5'd28; t_opc[3]  = MOD;   t_a[3]  = 32'd7;          t_b[3]  = 32'hFFFF_FFFD;  t_res[3]  = 64'd1;                  t_err[3]  = 1'b0;
    t_addr[4]  = 5'd27; t_opc[4]  = SUB;   t_a[4]  = 32'd5;          t_b[4]  = 32'd9;          t_res[4]  = 64'hFFFF_FFFF_FFFF_FFFC; t_err[4]  = 1'b0;
    t_addr[5]  = 5'd26; t_opc[5]  = PASSA; t_a[5]  = 32'hFFFF_FFFE;  t_b[5]  = 32'd9;          t_res[5]  = 64'hFFFF_FFFF_FFFF_FFFE; t_err[5]  = 1'b0;
    t_addr[6]  = 5'd25; t_opc[6]  = MOD;   t_a[6]  = 32'd5;          t_b[6]  = 32'd0;          t_res[6]  = 64'd0;                  t_err[6]  = 1'b1;
    t_addr[7]  = 5'd24; t_opc[7]  = ZERO;  t_a[7]  = 32'd3;          t_b[7]  = 32'd4;          t_res[7]  = 64'd0;                  t_err[7]  = 1'b0;
    t_addr[8]  = 5'd23; t_opc[8]  = MULT;  t_a[8]  = 32'hFFFF_FFFD;  t_b[8]  = 32'd4;          t_res[8]  = 64'hFFFF_FFFF_FFFF_FFF4; t_err[8]  = 1'b0;
    t_addr[9]  = 5'd22; t_opc[9]  = MULT;  t_a[9]  = 32'h7FFF_FFFF;  t_b[9]  = 32'h7FFF_FFFF;  t_res[9]  = 64'h3FFF_FFFF_0000_0001; t_err[9]  = 1'b0;
    t_addr[10] = 5'd21; t_opc[10] = DIV;   t_a[10] = 32'h8000_0000;  t_b[10] = 32'hFFFF_FFFF;  t_res[10] = 64'h0000_0000_8000_0000; t_err[10] = 1'b0;
    t_addr[11] = 5'd20; t_opc[11] = ADD;   t_a[11] = 32'h7FFF_FFFF;  t_b[11] = 32'd1;          t_res[11] = 64'h0000_0000_8000_0000; t_err[11] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      do_write(t_addr[i], t_opc[i], t_a[i], t_b[i]);
      do_read(t_addr[i]);
      checks++; if (rd_valid !== 1'b1 || rd_hit !== 1'b1) begin failures++; $display("FAIL alu[%0d]_valid_hit got=%b%b exp=11", i, rd_valid, rd_hit); end
      checks++; if (rd_result !== t_res[i]) begin failures++; $display("FAIL alu[%0d]_result got=%h exp=%h", i, rd_result, t_res[i]); end
      checks++; if (rd_err !== t_err[i]) begin failures++; $display("FAIL alu[%0d]_err got=%b exp=%b", i, rd_err, t_err[i]); end
      checks++; if (rd_opc !== t_opc[i]) begin failures++; $display("FAIL alu[%0d]_opc got=%0d exp=%0d", i, rd_opc, t_opc[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int j;
    logic [63:0] exp_res;
    clear_all = 1'b1;
    cyc();
    clear_all = 1'b0;
    for (int i = 0; i < 20; i++) begin
      do_write(5'(31 - i), ADD, 32'(31 - i), 32'd1);
    end
    pulses = 0;
    for (int k = 0; k <= 33; k++) begin
      read_en = (k < 32);
      read_pointer = 5'(k);
      cyc();
      if (rd_valid === 1'b1) pulses++;
      if (k >= 1 && k <= 32) begin
        j = k - 1;
        exp_res = (j >= 12) ? 64'(j + 1) : 64'd0;
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL b2b[%0d]_valid got=%b exp=1", j, rd_valid); end
        checks++; if (rd_hit !== (j >= 12)) begin failures++; $display("FAIL b2b[%0d]_hit got=%b exp=%b", j, rd_hit, (j >= 12)); end
        checks++; if (rd_result !== exp_res) begin failures++; $display("FAIL b2b[%0d]_result got=%h exp=%h", j, rd_result, exp_res); end
      end
    end
    read_en = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL b2b_tail_valid got=%b exp=0", rd_valid); end
    checks++; if (pulses !== 32) begin failures++; $display("FAIL b2b_pulses got=%0d exp=32", pulses); end
    checks++; if (valid_count !== 6'd20) begin failures++; $display("FAIL b2b_valid_count got=%0d exp=20", valid_count); end
  endtask

  task automatic test_bypass();
    load_en = 1'b1; write_pointer = 5'd3; opcode = PASSB; operand_a = 32'd1; operand_b = 32'd4;
    read_en = 1'b1; read_pointer = 5'd3;
    cyc();
    load_en = 1'b0; read_en = 1'b0;
    cyc();
    checks++; if (rd_valid !== 1'b1 || rd_hit !== 1'b1) begin failures++; $display("FAIL bypass_valid_hit got=%b%b exp=11", rd_valid, rd_hit); end
    checks++; if (rd_result !== 64'd4) begin failures++; $display("FAIL bypass_result got=%h exp=4", rd_result); end
    checks++; if (rd_opc !== PASSB) begin failures++; $display("FAIL bypass_opc got=%0d exp=2", rd_opc); end
    clear_all = 1'b1;
    cyc();
    clear_all = 1'b0;
    do_read(5'd3);
    checks++; if (rd_valid !== 1'b1 || rd_hit !== 1'b0) begin failures++; $display("FAIL clear_read_hit got=%b%b exp=10", rd_valid, rd_hit); end
    checks++; if (rd_result !== 64'd0 || rd_opc !== 3'd0 || rd_op_a !== 32'd0 || rd_op_b !== 32'd0) begin
      failures++; $display("FAIL clear_read_fields got=%h/%0d/%h/%h exp=0/0/0/0", rd_result, rd_opc, rd_op_a, rd_op_b);
    end
    checks++; if (valid_count !== 6'd0) begin failures++; $display("FAIL clear_valid_count got=%0d exp=0", valid_count); end
  endtask

  task automatic test_clear_interactions();
    // read in the same cycle as clear_all sees pre-clear state
    do_write(5'd7, ADD, 32'd1, 32'd1);
    clear_all = 1'b1; read_en = 1'b1; read_pointer = 5'd7;
    cyc();
    clear_all = 1'b0; read_en = 1'b0;
    cyc();
    checks++; if (rd_hit !== 1'b1 || rd_result !== 64'd2) begin failures++; $display("FAIL clr_same_read got=%b/%h exp=1/2", rd_hit, rd_result); end
    checks++; if (valid_count !== 6'd0) begin failures++; $display("FAIL clr_same_count got=%0d exp=0", valid_count); end
    // clear and load together keep only the written entry
    do_write(5'd7, ADD, 32'd1, 32'd1);
    clear_all = 1'b1;
    do_write(5'd9, SUB, 32'd10, 32'd3);
    clear_all = 1'b0;
    cyc();
    checks++; if (valid_count !== 6'd1) begin failures++; $display("FAIL clr_load_count got=%0d exp=1", valid_count); end
    do_read(5'd7);
    checks++; if (rd_hit !== 1'b0) begin failures++; $display("FAIL clr_load_old_hit got=%b exp=0", rd_hit); end
    do_read(5'd9);
    checks++; if (rd_hit !== 1'b1 || rd_result !== 64'd7) begin failures++; $display("FAIL clr_load_new got=%b/%h exp=1/7", rd_hit, rd_result); end
    // rewrite of a valid entry does not change the count
    do_write(5'd9, PASSA, 32'd5, 32'd0);
    cyc();
    checks++; if (valid_count !== 6'd1) begin failures++; $display("FAIL rewrite_count got=%0d exp=1", valid_count); end
    // read already in flight when clear_all arrives completes with old data
    read_en = 1'b1; read_pointer = 5'd9;
    cyc();
    read_en = 1'b0; clear_all = 1'b1;
    cyc();
    clear_all = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_hit !== 1'b1 || rd_result !== 64'd5) begin
      failures++; $display("FAIL inflight_clear got=%b%b/%h exp=11/5", rd_valid, rd_hit, rd_result);
    end
  endtask

  task automatic test_reset_inflight();
    do_write(5'd2, PASSA, 32'd77, 32'd0);
    read_en = 1'b1; read_pointer = 5'd2;
    cyc();
    cyc();
    checks++; if (rd_valid !== 1'b1 || rd_result !== 64'd77) begin failures++; $display("FAIL rst_pre got=%b/%h exp=1/77", rd_valid, rd_result); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || rd_hit !== 1'b0 || rd_err !== 1'b0) begin failures++; $display("FAIL rst_async_flags got=%b%b%b exp=000", rd_valid, rd_hit, rd_err); end
    checks++; if (rd_result !== 64'd0 || rd_op_a !== 32'd0 || rd_opc !== 3'd0) begin failures++; $display("FAIL rst_async_fields got=%h/%h/%0d exp=0", rd_result, rd_op_a, rd_opc); end
    checks++; if (valid_count !== 6'd0) begin failures++; $display("FAIL rst_async_count got=%0d exp=0", valid_count); end
    read_en = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_discard[%0d] got=%b exp=0", k, rd_valid); end
    end
    // first read right after release; the entry was invalidated by reset
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    read_en = 1'b1; read_pointer = 5'd2;
    cyc();
    read_en = 1'b0;
    cyc();
    checks++; if (rd_valid !== 1'b1 || rd_hit !== 1'b0) begin failures++; $display("FAIL rst_first_read got=%b%b exp=10", rd_valid, rd_hit); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add();
    test_alu_ops();
    test_back_to_back();
    test_bypass();
    test_clear_interactions();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_register_pipe.md
INSTR_REGISTER_PIPE -- requirements
Module: instr_register_pipe

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, meaning number of instruction entries (2..256).
REQ-002 The block SHALL have parameter OP_W, default 32, meaning signed operand width.
REQ-003 The block SHALL have parameter RES_W, default 64, meaning signed result width; RES_W >= 2*OP_W.
REQ-004 The block SHALL have parameter AW = $clog2(DEPTH), meaning pointer width.
REQ-005 The block SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-006 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port load_en  input  1  write strobe.
REQ-008 The block SHALL have port write_pointer  input  AW  write address.
REQ-009 The block SHALL have port opcode  input  3  ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
REQ-010 The block SHALL have ports operand_a and operand_b  input  OP_W each  signed operands.
REQ-011 The block SHALL have port clear_all  input  1  synchronous invalidate of all entries.
REQ-012 The block SHALL have port read_en  input  1  read request.
REQ-013 The block SHALL have port read_pointer  input  AW  read address.
REQ-014 The block SHALL have port rd_valid  output  1  result strobe.
REQ-015 The block SHALL have port rd_hit  output  1  addressed entry was valid.
REQ-016 The block SHALL have port rd_opc, rd_op_a, rd_op_b  output  3/OP_W/OP_W  stored fields.
REQ-017 The block SHALL have port rd_result  output  RES_W  computed result.
REQ-018 The block SHALL have port rd_err  output  1  DIV/MOD by zero.
REQ-019 The block SHALL have port valid_count  output  AW+1  number of valid entries.

Function
REQ-020 Write: load_en=1 at a rising edge SHALL store {opcode, operand_a, operand_b} at write_pointer and set that entry's valid bit.
REQ-021 A write_pointer >= DEPTH SHALL be ignored, with no storage change.
REQ-022 Read pipeline: read_en at edge N SHALL produce rd_valid=1 with all rd_* fields in the cycle following edge N+2 (latency 2), one result per request, fully pipelined (back-to-back every cycle).
REQ-023 Stage 1 SHALL capture the entry and valid bit; stage 2 SHALL compute and register the ALU result.
REQ-024 Same-cycle write and read of the same address SHALL bypass: the read returns the newly written data with rd_hit=1.
REQ-025 An invalid or out-of-range entry SHALL produce rd_hit=0, rd_opc=0, rd_op_a=0, rd_op_b=0, rd_result=0, rd_err=0.
REQ-026 ALU arithmetic SHALL be signed. ADD/SUB SHALL be sign-extended to RES_W. MULT SHALL be the full 2*OP_W product, sign-extended. DIV SHALL truncate toward zero. MOD SHALL take the sign of operand_a. PASSA/PASSB SHALL be sign-extended. ZERO SHALL produce 0.
REQ-027 DIV or MOD with op_b=0 SHALL produce rd_result=0 and rd_err=1.
REQ-028 DIV with op_a = most-negative and op_b = -1 SHALL produce the positive result +2^(OP_W-1) in RES_W width, with no error.
REQ-029 clear_all SHALL clear all valid bits at the edge; data need not be cleared.
REQ-030 clear_all and load_en in the same cycle SHALL leave only the written entry valid.
REQ-031 Reads already in the pipeline when clear_all is applied SHALL complete with pre-clear data.
REQ-032 A read_en in the same cycle as clear_all SHALL see pre-clear state.
REQ-033 valid_count SHALL update one cycle after any valid-bit change.
REQ-034 A rewrite of an already-valid entry SHALL NOT increment valid_count.

Reset
REQ-035 When reset_n=0, the block SHALL asynchronously clear all valid bits, both pipeline stages, rd_valid, rd_hit, rd_err, rd_* fields and valid_count to 0.
REQ-036 Storage array contents SHALL NOT require reset.
REQ-037 Reads in flight when reset is asserted SHALL be discarded.
REQ-038 The first read_en SHALL be accepted at the first rising edge after reset_n deasserts.

Verification
REQ-039 Reset, then write addr 5 = {ADD, -15, 7}, then read 5: rd_valid two cycles later, rd_hit=1, rd_result=-8 (sign-extended), rd_err=0.
REQ-040 Write addr 31 = {DIV, 9, 0}, then read 31: rd_result=0, rd_err=1. Write addr 30 = {MOD, -7, 3}, then read 30: rd_result=-1.
REQ-041 OP_W=32: write {MULT, 32'h7FFFFFFF, 32'h7FFFFFFF}; result SHALL be 64'h3FFFFFFF00000001. Write {DIV, 32'h80000000, -1}; result SHALL be 64'h0000000080000000.
REQ-042 Write 20 entries descending from 31, then read 0..31 back-to-back: 32 consecutive rd_valid pulses; rd_hit=1 only for 12..31; valid_count=20.
REQ-043 Same-cycle write and read of addr 3 = {PASSB, 1, 4}: rd_hit=1, rd_result=4. Then clear_all, then read 3: rd_hit=0, valid_count=0.
REQ-044 Assert reset_n=0 mid-read with 2 reads in flight: no rd_valid after reset; all outputs 0 immediately, asynchronously.
